// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter, one outstanding transaction at a time.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (m1 wins); otherwise round-robin.
module axi_rr_arbiter #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_USER_WIDTH = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // master 0 (instruction)
    input  logic [AXI_ID_WIDTH-1:0]       m0_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m0_aw_addr_i,
    input  logic [7:0]                    m0_aw_len_i,
    input  logic [2:0]                    m0_aw_size_i,
    input  logic [1:0]                    m0_aw_burst_i,
    input  logic [2:0]                    m0_aw_prot_i,
    input  logic [AXI_USER_WIDTH-1:0]     m0_aw_user_i,
    input  logic                          m0_aw_valid_i,
    output logic                          m0_aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     m0_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   m0_w_strb_i,
    input  logic                          m0_w_last_i,
    input  logic [AXI_USER_WIDTH-1:0]     m0_w_user_i,
    input  logic                          m0_w_valid_i,
    output logic                          m0_w_ready_o,
    output logic [AXI_ID_WIDTH-1:0]       m0_b_id_o,
    output logic [1:0]                    m0_b_resp_o,
    output logic [AXI_USER_WIDTH-1:0]     m0_b_user_o,
    output logic                          m0_b_valid_o,
    input  logic                          m0_b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]       m0_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m0_ar_addr_i,
    input  logic [7:0]                    m0_ar_len_i,
    input  logic [2:0]                    m0_ar_size_i,
    input  logic [1:0]                    m0_ar_burst_i,
    input  logic [2:0]                    m0_ar_prot_i,
    input  logic [AXI_USER_WIDTH-1:0]     m0_ar_user_i,
    input  logic                          m0_ar_valid_i,
    output logic                          m0_ar_ready_o,
    output logic [AXI_ID_WIDTH-1:0]       m0_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]     m0_r_data_o,
    output logic [1:0]                    m0_r_resp_o,
    output logic                          m0_r_last_o,
    output logic [AXI_USER_WIDTH-1:0]     m0_r_user_o,
    output logic                          m0_r_valid_o,
    input  logic                          m0_r_ready_i,
    // master 1 (data)
    input  logic [AXI_ID_WIDTH-1:0]       m1_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m1_aw_addr_i,
    input  logic [7:0]                    m1_aw_len_i,
    input  logic [2:0]                    m1_aw_size_i,
    input  logic [1:0]                    m1_aw_burst_i,
    input  logic [2:0]                    m1_aw_prot_i,
    input  logic [AXI_USER_WIDTH-1:0]     m1_aw_user_i,
    input  logic                          m1_aw_valid_i,
    output logic                          m1_aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     m1_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   m1_w_strb_i,
    input  logic                          m1_w_last_i,
    input  logic [AXI_USER_WIDTH-1:0]     m1_w_user_i,
    input  logic                          m1_w_valid_i,
    output logic                          m1_w_ready_o,
    output logic [AXI_ID_WIDTH-1:0]       m1_b_id_o,
    output logic [1:0]                    m1_b_resp_o,
    output logic [AXI_USER_WIDTH-1:0]     m1_b_user_o,
    output logic                          m1_b_valid_o,
    input  logic                          m1_b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]       m1_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m1_ar_addr_i,
    input  logic [7:0]                    m1_ar_len_i,
    input  logic [2:0]                    m1_ar_size_i,
    input  logic [1:0]                    m1_ar_burst_i,
    input  logic [2:0]                    m1_ar_prot_i,
    input  logic [AXI_USER_WIDTH-1:0]     m1_ar_user_i,
    input  logic                          m1_ar_valid_i,
    output logic                          m1_ar_ready_o,
    output logic [AXI_ID_WIDTH-1:0]       m1_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]     m1_r_data_o,
    output logic [1:0]                    m1_r_resp_o,
    output logic                          m1_r_last_o,
    output logic [AXI_USER_WIDTH-1:0]     m1_r_user_o,
    output logic                          m1_r_valid_o,
    input  logic                          m1_r_ready_i,
    // shared slave
    output logic [AXI_ID_WIDTH-1:0]       s_aw_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr_o,
    output logic [7:0]                    s_aw_len_o,
    output logic [2:0]                    s_aw_size_o,
    output logic [1:0]                    s_aw_burst_o,
    output logic [2:0]                    s_aw_prot_o,
    output logic [AXI_USER_WIDTH-1:0]     s_aw_user_o,
    output logic                          s_aw_valid_o,
    input  logic                          s_aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     s_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb_o,
    output logic                          s_w_last_o,
    output logic [AXI_USER_WIDTH-1:0]     s_w_user_o,
    output logic                          s_w_valid_o,
    input  logic                          s_w_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]       s_b_id_i,
    input  logic [1:0]                    s_b_resp_i,
    input  logic [AXI_USER_WIDTH-1:0]     s_b_user_i,
    input  logic                          s_b_valid_i,
    output logic                          s_b_ready_o,
    output logic [AXI_ID_WIDTH-1:0]       s_ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr_o,
    output logic [7:0]                    s_ar_len_o,
    output logic [2:0]                    s_ar_size_o,
    output logic [1:0]                    s_ar_burst_o,
    output logic [2:0]                    s_ar_prot_o,
    output logic [AXI_USER_WIDTH-1:0]     s_ar_user_o,
    output logic                          s_ar_valid_o,
    input  logic                          s_ar_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]       s_r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]     s_r_data_i,
    input  logic [1:0]                    s_r_resp_i,
    input  logic                          s_r_last_i,
    input  logic [AXI_USER_WIDTH-1:0]     s_r_user_i,
    input  logic                          s_r_valid_i,
    output logic                          s_r_ready_o,
    // status
    output logic [1:0]                    gnt_o,
    output logic                          busy_o
);

    // state   | meaning
    // IDLE    | no owner, arbitrate among AR/AW requesters
    // RD_ADDR | AR forwarded, waiting for s ar_ready
    // RD_DATA | R forwarded until the rlast handshake
    // WR_ADDR | AW forwarded, waiting for s aw_ready
    // WR_DATA | W forwarded until the wlast handshake
    // WR_RESP | waiting for the B handshake
    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        req0, req1, win;
    logic        sel_aw_valid, sel_w_valid, sel_w_last, sel_ar_valid;
    logic        sel_b_ready, sel_r_ready;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif

    assign req0 = m0_aw_valid_i | m0_ar_valid_i;
    assign req1 = m1_aw_valid_i | m1_ar_valid_i;

    assign sel_aw_valid = sel_q ? m1_aw_valid_i : m0_aw_valid_i;
    assign sel_w_valid  = sel_q ? m1_w_valid_i  : m0_w_valid_i;
    assign sel_w_last   = sel_q ? m1_w_last_i   : m0_w_last_i;
    assign sel_ar_valid = sel_q ? m1_ar_valid_i : m0_ar_valid_i;
    assign sel_b_ready  = sel_q ? m1_b_ready_i  : m0_b_ready_i;
    assign sel_r_ready  = sel_q ? m1_r_ready_i  : m0_r_ready_i;

    always_comb begin
        win = req1;
`ifndef AXI_ARB_FIXED_PRIO_EN
        // on a tie, the master that was not granted last goes first
        if (req0 && req1) win = ~last_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
`ifndef AXI_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifndef AXI_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d = win;
`ifndef AXI_ARB_FIXED_PRIO_EN
                    last_d = win;
`endif
                    // pending stores drain before loads from the same master
                    state_d = (win ? m1_aw_valid_i : m0_aw_valid_i) ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: if (sel_ar_valid && s_ar_ready_i) state_d = RD_DATA;
            RD_DATA: if (s_r_valid_i && sel_r_ready && s_r_last_i) state_d = IDLE;
            WR_ADDR: if (sel_aw_valid && s_aw_ready_i) state_d = WR_DATA;
            WR_DATA: if (sel_w_valid && s_w_ready_i && sel_w_last) state_d = WR_RESP;
            WR_RESP: if (s_b_valid_i && sel_b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        gnt_d  = (state_d == IDLE) ? 2'b00 : (sel_d ? 2'b10 : 2'b01);
    end

    always_comb begin
        s_aw_valid_o  = 1'b0;
        s_w_valid_o   = 1'b0;
        s_ar_valid_o  = 1'b0;
        s_b_ready_o   = 1'b0;
        s_r_ready_o   = 1'b0;
        m0_aw_ready_o = 1'b0;
        m0_w_ready_o  = 1'b0;
        m0_ar_ready_o = 1'b0;
        m0_b_valid_o  = 1'b0;
        m0_r_valid_o  = 1'b0;
        m1_aw_ready_o = 1'b0;
        m1_w_ready_o  = 1'b0;
        m1_ar_ready_o = 1'b0;
        m1_b_valid_o  = 1'b0;
        m1_r_valid_o  = 1'b0;
        case (state_q)
            RD_ADDR: begin
                s_ar_valid_o = sel_ar_valid;
                if (sel_q) m1_ar_ready_o = s_ar_ready_i;
                else       m0_ar_ready_o = s_ar_ready_i;
            end
            RD_DATA: begin
                s_r_ready_o = sel_r_ready;
                if (sel_q) m1_r_valid_o = s_r_valid_i;
                else       m0_r_valid_o = s_r_valid_i;
            end
            WR_ADDR: begin
                s_aw_valid_o = sel_aw_valid;
                if (sel_q) m1_aw_ready_o = s_aw_ready_i;
                else       m0_aw_ready_o = s_aw_ready_i;
            end
            WR_DATA: begin
                s_w_valid_o = sel_w_valid;
                if (sel_q) m1_w_ready_o = s_w_ready_i;
                else       m0_w_ready_o = s_w_ready_i;
            end
            WR_RESP: begin
                s_b_ready_o = sel_b_ready;
                if (sel_q) m1_b_valid_o = s_b_valid_i;
                else       m0_b_valid_o = s_b_valid_i;
            end
            default: ;
        endcase
    end

    // payloads follow the owner; only valid/ready are gated by state
    assign s_aw_id_o    = sel_q ? m1_aw_id_i    : m0_aw_id_i;
    assign s_aw_addr_o  = sel_q ? m1_aw_addr_i  : m0_aw_addr_i;
    assign s_aw_len_o   = sel_q ? m1_aw_len_i   : m0_aw_len_i;
    assign s_aw_size_o  = sel_q ? m1_aw_size_i  : m0_aw_size_i;
    assign s_aw_burst_o = sel_q ? m1_aw_burst_i : m0_aw_burst_i;
    assign s_aw_prot_o  = sel_q ? m1_aw_prot_i  : m0_aw_prot_i;
    assign s_aw_user_o  = sel_q ? m1_aw_user_i  : m0_aw_user_i;
    assign s_w_data_o   = sel_q ? m1_w_data_i   : m0_w_data_i;
    assign s_w_strb_o   = sel_q ? m1_w_strb_i   : m0_w_strb_i;
    assign s_w_last_o   = sel_w_last;
    assign s_w_user_o   = sel_q ? m1_w_user_i   : m0_w_user_i;
    assign s_ar_id_o    = sel_q ? m1_ar_id_i    : m0_ar_id_i;
    assign s_ar_addr_o  = sel_q ? m1_ar_addr_i  : m0_ar_addr_i;
    assign s_ar_len_o   = sel_q ? m1_ar_len_i   : m0_ar_len_i;
    assign s_ar_size_o  = sel_q ? m1_ar_size_i  : m0_ar_size_i;
    assign s_ar_burst_o = sel_q ? m1_ar_burst_i : m0_ar_burst_i;
    assign s_ar_prot_o  = sel_q ? m1_ar_prot_i  : m0_ar_prot_i;
    assign s_ar_user_o  = sel_q ? m1_ar_user_i  : m0_ar_user_i;

    assign m0_b_id_o   = s_b_id_i;
    assign m0_b_resp_o = s_b_resp_i;
    assign m0_b_user_o = s_b_user_i;
    assign m1_b_id_o   = s_b_id_i;
    assign m1_b_resp_o = s_b_resp_i;
    assign m1_b_user_o = s_b_user_i;
    assign m0_r_id_o   = s_r_id_i;
    assign m0_r_data_o = s_r_data_i;
    assign m0_r_resp_o = s_r_resp_i;
    assign m0_r_last_o = s_r_last_i;
    assign m0_r_user_o = s_r_user_i;
    assign m1_r_id_o   = s_r_id_i;
    assign m1_r_data_o = s_r_data_i;
    assign m1_r_resp_o = s_r_resp_i;
    assign m1_r_last_o = s_r_last_i;
    assign m1_r_user_o = s_r_user_i;

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter; expectations follow AXI_ARB_FIXED_PRIO_EN.
module tb_axi_rr_arbiter;

    logic clk_i, rst_ni;
    int   checks, errors;

    logic m0_aw_id, m0_aw_user, m0_aw_valid, m0_aw_ready;
    logic [31:0] m0_aw_addr; logic [7:0] m0_aw_len; logic [2:0] m0_aw_size, m0_aw_prot; logic [1:0] m0_aw_burst;
    logic [31:0] m0_w_data; logic [3:0] m0_w_strb; logic m0_w_last, m0_w_user, m0_w_valid, m0_w_ready;
    logic m0_b_id, m0_b_user, m0_b_valid, m0_b_ready; logic [1:0] m0_b_resp;
    logic m0_ar_id, m0_ar_user, m0_ar_valid, m0_ar_ready;
    logic [31:0] m0_ar_addr; logic [7:0] m0_ar_len; logic [2:0] m0_ar_size, m0_ar_prot; logic [1:0] m0_ar_burst;
    logic m0_r_id, m0_r_last, m0_r_user, m0_r_valid, m0_r_ready; logic [31:0] m0_r_data; logic [1:0] m0_r_resp;

    logic m1_aw_id, m1_aw_user, m1_aw_valid, m1_aw_ready;
    logic [31:0] m1_aw_addr; logic [7:0] m1_aw_len; logic [2:0] m1_aw_size, m1_aw_prot; logic [1:0] m1_aw_burst;
    logic [31:0] m1_w_data; logic [3:0] m1_w_strb; logic m1_w_last, m1_w_user, m1_w_valid, m1_w_ready;
    logic m1_b_id, m1_b_user, m1_b_valid, m1_b_ready; logic [1:0] m1_b_resp;
    logic m1_ar_id, m1_ar_user, m1_ar_valid, m1_ar_ready;
    logic [31:0] m1_ar_addr; logic [7:0] m1_ar_len; logic [2:0] m1_ar_size, m1_ar_prot; logic [1:0] m1_ar_burst;
    logic m1_r_id, m1_r_last, m1_r_user, m1_r_valid, m1_r_ready; logic [31:0] m1_r_data; logic [1:0] m1_r_resp;

    logic s_aw_id, s_aw_user, s_aw_valid, s_aw_ready;
    logic [31:0] s_aw_addr; logic [7:0] s_aw_len; logic [2:0] s_aw_size, s_aw_prot; logic [1:0] s_aw_burst;
    logic [31:0] s_w_data; logic [3:0] s_w_strb; logic s_w_last, s_w_user, s_w_valid, s_w_ready;
    logic s_b_id, s_b_user, s_b_valid, s_b_ready; logic [1:0] s_b_resp;
    logic s_ar_id, s_ar_user, s_ar_valid, s_ar_ready;
    logic [31:0] s_ar_addr; logic [7:0] s_ar_len; logic [2:0] s_ar_size, s_ar_prot; logic [1:0] s_ar_burst;
    logic s_r_id, s_r_last, s_r_user, s_r_valid, s_r_ready; logic [31:0] s_r_data; logic [1:0] s_r_resp;

    logic [1:0] gnt;
    logic       busy;

    axi_rr_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_aw_id_i(m0_aw_id), .m0_aw_addr_i(m0_aw_addr), .m0_aw_len_i(m0_aw_len), .m0_aw_size_i(m0_aw_size),
        .m0_aw_burst_i(m0_aw_burst), .m0_aw_prot_i(m0_aw_prot), .m0_aw_user_i(m0_aw_user),
        .m0_aw_valid_i(m0_aw_valid), .m0_aw_ready_o(m0_aw_ready),
        .m0_w_data_i(m0_w_data), .m0_w_strb_i(m0_w_strb), .m0_w_last_i(m0_w_last), .m0_w_user_i(m0_w_user),
        .m0_w_valid_i(m0_w_valid), .m0_w_ready_o(m0_w_ready),
        .m0_b_id_o(m0_b_id), .m0_b_resp_o(m0_b_resp), .m0_b_user_o(m0_b_user), .m0_b_valid_o(m0_b_valid),
        .m0_b_ready_i(m0_b_ready),
        .m0_ar_id_i(m0_ar_id), .m0_ar_addr_i(m0_ar_addr), .m0_ar_len_i(m0_ar_len), .m0_ar_size_i(m0_ar_size),
        .m0_ar_burst_i(m0_ar_burst), .m0_ar_prot_i(m0_ar_prot), .m0_ar_user_i(m0_ar_user),
        .m0_ar_valid_i(m0_ar_valid), .m0_ar_ready_o(m0_ar_ready),
        .m0_r_id_o(m0_r_id), .m0_r_data_o(m0_r_data), .m0_r_resp_o(m0_r_resp), .m0_r_last_o(m0_r_last),
        .m0_r_user_o(m0_r_user), .m0_r_valid_o(m0_r_valid), .m0_r_ready_i(m0_r_ready),
        .m1_aw_id_i(m1_aw_id), .m1_aw_addr_i(m1_aw_addr), .m1_aw_len_i(m1_aw_len), .m1_aw_size_i(m1_aw_size),
        .m1_aw_burst_i(m1_aw_burst), .m1_aw_prot_i(m1_aw_prot), .m1_aw_user_i(m1_aw_user),
        .m1_aw_valid_i(m1_aw_valid), .m1_aw_ready_o(m1_aw_ready),
        .m1_w_data_i(m1_w_data), .m1_w_strb_i(m1_w_strb), .m1_w_last_i(m1_w_last), .m1_w_user_i(m1_w_user),
        .m1_w_valid_i(m1_w_valid), .m1_w_ready_o(m1_w_ready),
        .m1_b_id_o(m1_b_id), .m1_b_resp_o(m1_b_resp), .m1_b_user_o(m1_b_user), .m1_b_valid_o(m1_b_valid),
        .m1_b_ready_i(m1_b_ready),
        .m1_ar_id_i(m1_ar_id), .m1_ar_addr_i(m1_ar_addr), .m1_ar_len_i(m1_ar_len), .m1_ar_size_i(m1_ar_size),
        .m1_ar_burst_i(m1_ar_burst), .m1_ar_prot_i(m1_ar_prot), .m1_ar_user_i(m1_ar_user),
        .m1_ar_valid_i(m1_ar_valid), .m1_ar_ready_o(m1_ar_ready),
        .m1_r_id_o(m1_r_id), .m1_r_data_o(m1_r_data), .m1_r_resp_o(m1_r_resp), .m1_r_last_o(m1_r_last),
        .m1_r_user_o(m1_r_user), .m1_r_valid_o(m1_r_valid), .m1_r_ready_i(m1_r_ready),
        .s_aw_id_o(s_aw_id), .s_aw_addr_o(s_aw_addr), .s_aw_len_o(s_aw_len), .s_aw_size_o(s_aw_size),
        .s_aw_burst_o(s_aw_burst), .s_aw_prot_o(s_aw_prot), .s_aw_user_o(s_aw_user),
        .s_aw_valid_o(s_aw_valid), .s_aw_ready_i(s_aw_ready),
        .s_w_data_o(s_w_data), .s_w_strb_o(s_w_strb), .s_w_last_o(s_w_last), .s_w_user_o(s_w_user),
        .s_w_valid_o(s_w_valid), .s_w_ready_i(s_w_ready),
        .s_b_id_i(s_b_id), .s_b_resp_i(s_b_resp), .s_b_user_i(s_b_user), .s_b_valid_i(s_b_valid),
        .s_b_ready_o(s_b_ready),
        .s_ar_id_o(s_ar_id), .s_ar_addr_o(s_ar_addr), .s_ar_len_o(s_ar_len), .s_ar_size_o(s_ar_size),
        .s_ar_burst_o(s_ar_burst), .s_ar_prot_o(s_ar_prot), .s_ar_user_o(s_ar_user),
        .s_ar_valid_o(s_ar_valid), .s_ar_ready_i(s_ar_ready),
        .s_r_id_i(s_r_id), .s_r_data_i(s_r_data), .s_r_resp_i(s_r_resp), .s_r_last_i(s_r_last),
        .s_r_user_i(s_r_user), .s_r_valid_i(s_r_valid), .s_r_ready_o(s_r_ready),
        .gnt_o(gnt), .busy_o(busy)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic init_inputs();
        {m0_aw_id, m0_aw_user, m0_aw_valid, m0_aw_addr, m0_aw_len, m0_aw_size, m0_aw_prot, m0_aw_burst} = '0;
        {m0_w_data, m0_w_strb, m0_w_last, m0_w_user, m0_w_valid, m0_b_ready, m0_r_ready} = '0;
        {m0_ar_id, m0_ar_user, m0_ar_valid, m0_ar_addr, m0_ar_len, m0_ar_size, m0_ar_prot, m0_ar_burst} = '0;
        {m1_aw_id, m1_aw_user, m1_aw_valid, m1_aw_addr, m1_aw_len, m1_aw_size, m1_aw_prot, m1_aw_burst} = '0;
        {m1_w_data, m1_w_strb, m1_w_last, m1_w_user, m1_w_valid, m1_b_ready, m1_r_ready} = '0;
        {m1_ar_id, m1_ar_user, m1_ar_valid, m1_ar_addr, m1_ar_len, m1_ar_size, m1_ar_prot, m1_ar_burst} = '0;
        {s_aw_ready, s_w_ready, s_ar_ready, s_b_id, s_b_resp, s_b_user, s_b_valid} = '0;
        {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user, s_r_valid} = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        init_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if ({s_ar_valid, s_aw_valid, s_w_valid, s_b_ready, s_r_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_s_valids: got %b want 00000",
                               {s_ar_valid, s_aw_valid, s_w_valid, s_b_ready, s_r_ready});
        end
        checks++;
        if ({m0_ar_ready, m0_aw_ready, m0_w_ready, m0_r_valid, m0_b_valid,
             m1_ar_ready, m1_aw_ready, m1_w_ready, m1_r_valid, m1_b_valid} !== 10'b0) begin
            errors++; $display("FAIL reset_m_handshakes: some master ready/valid is nonzero");
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        m0_ar_valid = 1'b1; m0_ar_addr = 32'h80; m0_ar_len = 8'd0; s_ar_ready = 1'b1;
        #1;
        checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL rd_early_ar: got %b want 0", s_ar_valid); end
        tick();
        #1;
        checks++; if (s_ar_valid !== 1'b1) begin errors++; $display("FAIL rd_ar_valid: got %b want 1", s_ar_valid); end
        checks++; if (s_ar_addr !== 32'h80) begin errors++; $display("FAIL rd_ar_addr: got %h want 80", s_ar_addr); end
        checks++; if (m0_ar_ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ar_ready: got %b want 1", m0_ar_ready); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt_addr: got %b want 01", gnt); end
        tick();
        m0_ar_valid = 1'b0;
        s_r_valid = 1'b1; s_r_data = 32'hDEADBEEF; s_r_last = 1'b1; m0_r_ready = 1'b1;
        #1;
        checks++; if (m0_r_valid !== 1'b1) begin errors++; $display("FAIL rd_m0_r_valid: got %b want 1", m0_r_valid); end
        checks++; if (m0_r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_m0_r_data: got %h want deadbeef", m0_r_data); end
        checks++; if (m1_r_valid !== 1'b0) begin errors++; $display("FAIL rd_m1_r_valid: got %b want 0", m1_r_valid); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rd_gnt_data: got %b want 01", gnt); end
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0; m0_r_ready = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rd_gnt_done: got %b want 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_done: got %b want 0", busy); end
    endtask

    // each read takes IDLE, RD_ADDR, RD_DATA; the grant shows for 2 of every 3 cycles
    task automatic test_arbitration();
        logic [1:0] exp_gnt;
        do_reset();
        m0_ar_valid = 1'b1; m1_ar_valid = 1'b1; m0_ar_addr = 32'h10; m1_ar_addr = 32'h20;
        s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_last = 1'b1; m0_r_ready = 1'b1; m1_r_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
`ifdef AXI_ARB_FIXED_PRIO_EN
            exp_gnt = (i % 3 == 2) ? 2'b00 : 2'b10;
`else
            exp_gnt = (i % 3 == 2) ? 2'b00 : (((i / 3) % 2 == 1) ? 2'b10 : 2'b01);
`endif
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL arb_gnt[%0d]: got %b want %b", i, gnt, exp_gnt); end
            if (exp_gnt != 2'b01) begin
                checks++; if (m0_ar_ready !== 1'b0) begin errors++; $display("FAIL arb_m0_ar_ready[%0d]: got %b want 0", i, m0_ar_ready); end
            end
        end
        m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
        s_r_valid = 1'b0; s_r_last = 1'b0; m0_r_ready = 1'b0; m1_r_ready = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        tick();
        m1_w_valid = 1'b1; m1_w_data = 32'd1; m1_w_last = 1'b0; s_w_ready = 1'b1; s_aw_ready = 1'b1;
        #1;
        checks++; if (m1_w_ready !== 1'b0) begin errors++; $display("FAIL wr_early_w_ready: got %b want 0", m1_w_ready); end
        checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL wr_early_s_w_valid: got %b want 0", s_w_valid); end
        tick();
        m1_aw_valid = 1'b1; m1_aw_addr = 32'h1000; m1_aw_len = 8'd3; m1_aw_id = 1'b1;
        #1;
        checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL wr_early_aw: got %b want 0", s_aw_valid); end
        tick();
        #1;
        checks++; if (s_aw_valid !== 1'b1) begin errors++; $display("FAIL wr_aw_valid: got %b want 1", s_aw_valid); end
        checks++; if (s_aw_addr !== 32'h1000) begin errors++; $display("FAIL wr_aw_addr: got %h want 1000", s_aw_addr); end
        checks++; if (s_aw_len !== 8'd3) begin errors++; $display("FAIL wr_aw_len: got %0d want 3", s_aw_len); end
        checks++; if (s_aw_id !== 1'b1) begin errors++; $display("FAIL wr_aw_id: got %b want 1", s_aw_id); end
        checks++; if (m1_w_ready !== 1'b0) begin errors++; $display("FAIL wr_w_ready_in_aw: got %b want 0", m1_w_ready); end
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", gnt); end
        tick();
        m1_aw_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            m1_w_data = i; m1_w_last = (i == 4);
            #1;
            checks++; if (s_w_valid !== 1'b1) begin errors++; $display("FAIL wr_beat%0d_valid: got %b want 1", i, s_w_valid); end
            checks++; if (s_w_data !== 32'(i)) begin errors++; $display("FAIL wr_beat%0d_data: got %0d want %0d", i, s_w_data, i); end
            checks++; if (s_w_last !== (i == 4)) begin errors++; $display("FAIL wr_beat%0d_last: got %b", i, s_w_last); end
            checks++; if (m1_w_ready !== 1'b1) begin errors++; $display("FAIL wr_beat%0d_ready: got %b want 1", i, m1_w_ready); end
            tick();
        end
        m1_w_valid = 1'b0; m1_w_last = 1'b0;
        s_b_valid = 1'b1; s_b_resp = 2'b00; s_b_id = 1'b1; m1_b_ready = 1'b1;
        #1;
        checks++; if (m1_b_valid !== 1'b1) begin errors++; $display("FAIL wr_m1_b_valid: got %b want 1", m1_b_valid); end
        checks++; if (m1_b_resp !== 2'b00) begin errors++; $display("FAIL wr_m1_b_resp: got %b want 00", m1_b_resp); end
        checks++; if (m1_b_id !== 1'b1) begin errors++; $display("FAIL wr_m1_b_id: got %b want 1", m1_b_id); end
        checks++; if (m0_b_valid !== 1'b0) begin errors++; $display("FAIL wr_m0_b_valid: got %b want 0", m0_b_valid); end
        checks++; if (s_b_ready !== 1'b1) begin errors++; $display("FAIL wr_s_b_ready: got %b want 1", s_b_ready); end
        tick();
        s_b_valid = 1'b0; s_b_id = 1'b0; m1_b_ready = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_same_master();
        tick();
        m1_aw_valid = 1'b1; m1_aw_addr = 32'h2000; m1_aw_len = 8'd0;
        m1_ar_valid = 1'b1; m1_ar_addr = 32'h3000; m1_ar_len = 8'd0;
        s_aw_ready = 1'b1; s_ar_ready = 1'b1; s_w_ready = 1'b1;
        tick();
        #1;
        checks++; if (s_aw_valid !== 1'b1) begin errors++; $display("FAIL sm_aw_first: got %b want 1", s_aw_valid); end
        checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL sm_ar_in_aw: got %b want 0", s_ar_valid); end
        tick();
        m1_aw_valid = 1'b0; m1_w_valid = 1'b1; m1_w_last = 1'b1; m1_w_data = 32'hAA;
        #1;
        checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL sm_ar_in_w: got %b want 0", s_ar_valid); end
        tick();
        m1_w_valid = 1'b0; m1_w_last = 1'b0; s_b_valid = 1'b1; m1_b_ready = 1'b1;
        #1;
        checks++; if (m1_b_valid !== 1'b1) begin errors++; $display("FAIL sm_b_valid: got %b want 1", m1_b_valid); end
        checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL sm_ar_in_b: got %b want 0", s_ar_valid); end
        tick();
        s_b_valid = 1'b0; m1_b_ready = 1'b0;
        #1;
        checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL sm_ar_in_idle: got %b want 0", s_ar_valid); end
        tick();
        #1;
        checks++; if (s_ar_valid !== 1'b1) begin errors++; $display("FAIL sm_ar_after_b: got %b want 1", s_ar_valid); end
        checks++; if (s_ar_addr !== 32'h3000) begin errors++; $display("FAIL sm_ar_addr: got %h want 3000", s_ar_addr); end
        tick();
        m1_ar_valid = 1'b0; s_r_valid = 1'b1; s_r_last = 1'b1; m1_r_ready = 1'b1;
        #1;
        checks++; if (m1_r_valid !== 1'b1) begin errors++; $display("FAIL sm_m1_r_valid: got %b want 1", m1_r_valid); end
        checks++; if (m0_r_valid !== 1'b0) begin errors++; $display("FAIL sm_m0_r_valid: got %b want 0", m0_r_valid); end
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0; m1_r_ready = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL sm_gnt_done: got %b want 00", gnt); end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        m0_ar_valid = 1'b1; m0_ar_addr = 32'h100; m0_ar_len = 8'd3; s_ar_ready = 1'b1;
        tick();
        tick();
        m0_ar_valid = 1'b0; s_r_valid = 1'b1; s_r_data = 32'd1; s_r_last = 1'b0; m0_r_ready = 1'b1;
        #1;
        checks++; if (m0_r_valid !== 1'b1) begin errors++; $display("FAIL rst_beat1: got %b want 1", m0_r_valid); end
        tick();
        s_r_data = 32'd2;
        #1;
        checks++; if (m0_r_valid !== 1'b1) begin errors++; $display("FAIL rst_beat2: got %b want 1", m0_r_valid); end
        rst_ni = 1'b0;
        #1;
        checks++; if (m0_r_valid !== 1'b0) begin errors++; $display("FAIL rst_async_r_valid: got %b want 0", m0_r_valid); end
        checks++; if (s_r_ready !== 1'b0) begin errors++; $display("FAIL rst_async_r_ready: got %b want 0", s_r_ready); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_async_gnt: got %b want 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        s_r_valid = 1'b0; m0_r_ready = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        m0_ar_valid = 1'b1; m0_ar_addr = 32'h40; m0_ar_len = 8'd0;
        tick();
        #1;
        checks++; if (s_ar_valid !== 1'b1) begin errors++; $display("FAIL rst_next_ar_valid: got %b want 1", s_ar_valid); end
        checks++; if (s_ar_addr !== 32'h40) begin errors++; $display("FAIL rst_next_ar_addr: got %h want 40", s_ar_addr); end
        tick();
        m0_ar_valid = 1'b0; s_r_valid = 1'b1; s_r_data = 32'h12345678; s_r_last = 1'b1; m0_r_ready = 1'b1;
        #1;
        checks++; if (m0_r_data !== 32'h12345678 || m0_r_valid !== 1'b1) begin
            errors++; $display("FAIL rst_next_r: got valid %b data %h want 1 12345678", m0_r_valid, m0_r_data);
        end
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0; m0_r_ready = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_next_gnt_done: got %b want 00", gnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_read();
        test_arbitration();
        test_write_burst();
        test_same_master();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
